// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared FSM state type and default resolution for the PWM duty decoder
package pwm_pkg;

    localparam int PWM_N_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ALIGN   = 2'd1,
        MEASURE = 2'd2
    } pwm_state_t;

endpackage

// File: rtl/pwm_decoder_if.sv
// rtl/pwm_decoder_if.sv - control and result signal bundle around the PWM duty decoder
interface pwm_decoder_if #(
    parameter int N = 8
) (
    input logic clk
);
    logic         ena;
    logic         step;
    logic         pwm_in;
    logic [N-1:0] duty;
    logic         valid;
    logic         stuck;

    // The master drives measurement control and the raw waveform, the slave answers with results
    modport master (input clk, output ena, output step, output pwm_in,
                    input duty, input valid, input stuck);
    modport slave  (input clk, input ena, input step, input pwm_in,
                    output duty, output valid, output stuck);

endinterface

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for a single asynchronous bit
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] sync_q;

    // Shift the raw input through two flops every clock to settle metastability
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/pwm_decoder.sv
// rtl/pwm_decoder.sv - measures PWM duty over 2^N-sample windows aligned to a rising edge
module pwm_decoder
    import pwm_pkg::*;
#(
    parameter int N = PWM_N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         step,
    input  logic         pwm_in,
    output logic [N-1:0] duty,
    output logic         valid,
    output logic         stuck
);
    localparam logic [N-1:0] CNT_MAX = {N{1'b1}};
    localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N:0]   HI_ONE  = {{N{1'b0}}, 1'b1};

    logic         sample;
    pwm_state_t   state_q, state_d;
    logic [N-1:0] idx_q, idx_d;
    logic [N:0]   hi_q, hi_d;
    logic [N-1:0] tmo_q, tmo_d;
    logic         prev_q, prev_d;
    logic [N-1:0] duty_q, duty_d;
    logic         stuck_q, stuck_d;
    logic         valid_q, valid_d;
    logic [N:0]   hi_sum;

    sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (pwm_in),
        .q_o (sample)
    );

    // Decide next state, counter updates and whether this sample publishes a result
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hi_d    = hi_q;
        tmo_d   = tmo_q;
        prev_d  = prev_q;
        duty_d  = duty_q;
        stuck_d = stuck_q;
        valid_d = 1'b0;
        hi_sum  = hi_q + {{N{1'b0}}, sample};

        if (!ena) begin
            // Partial window is dropped; prev forced high so a high level on re-enable is no edge
            state_d = IDLE;
            idx_d   = '0;
            hi_d    = '0;
            tmo_d   = '0;
            prev_d  = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ALIGN;
                    idx_d   = '0;
                    hi_d    = '0;
                    tmo_d   = '0;
                    prev_d  = 1'b1;
                end
                ALIGN: begin
                    if (step) begin
                        prev_d = sample;
                        if (sample && !prev_q) begin
                            // The edge sample itself is the first high sample of the window
                            state_d = MEASURE;
                            idx_d   = CNT_ONE;
                            hi_d    = HI_ONE;
                            tmo_d   = '0;
                        end else if (tmo_q == CNT_MAX) begin
                            duty_d  = sample ? {N{1'b1}} : {N{1'b0}};
                            stuck_d = 1'b1;
                            valid_d = 1'b1;
                            tmo_d   = '0;
                        end else begin
                            tmo_d = tmo_q + CNT_ONE;
                        end
                    end
                end
                MEASURE: begin
                    if (step) begin
                        prev_d = sample;
                        if (idx_q == CNT_MAX) begin
                            // A full-high window counts 2^N, which does not fit: saturate
                            duty_d  = hi_sum[N] ? {N{1'b1}} : hi_sum[N-1:0];
                            stuck_d = 1'b0;
                            valid_d = 1'b1;
                            idx_d   = '0;
                            hi_d    = '0;
                        end else begin
                            idx_d = idx_q + CNT_ONE;
                            hi_d  = hi_sum;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Register FSM state, counters and published outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hi_q    <= '0;
            tmo_q   <= '0;
            prev_q  <= 1'b1;
            duty_q  <= '0;
            stuck_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hi_q    <= hi_d;
            tmo_q   <= tmo_d;
            prev_q  <= prev_d;
            duty_q  <= duty_d;
            stuck_q <= stuck_d;
            valid_q <= valid_d;
        end
    end

    assign duty  = duty_q;
    assign stuck = stuck_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// tb/tb_pwm_decoder.sv - randomized and directed bench for pwm_decoder against a window-level model
module tb_pwm_decoder;
    localparam int N   = 4;
    localparam int WIN = 16;

    logic clk;
    logic rst;

    pwm_decoder_if #(.N(N)) bus (.clk(clk));

    pwm_decoder #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (bus.ena),
        .step   (bus.step),
        .pwm_in (bus.pwm_in),
        .duty   (bus.duty),
        .valid  (bus.valid),
        .stuck  (bus.stuck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: sample stream in, publications out
    bit s1, s2;
    bit m_active, m_aligned, m_prev;
    int m_nohit;
    int win_q[$];
    int e_duty;
    bit e_stuck, e_valid;
    int m_pulses;

    always @(posedge clk) begin
        bit s;
        int sum;
        e_valid = 1'b0;
        if (rst) begin
            s1 = 0; s2 = 0;
            m_active = 0; m_aligned = 0; m_prev = 1; m_nohit = 0;
            win_q.delete();
            e_duty = 0; e_stuck = 0;
        end else begin
            s  = s2;
            s2 = s1;
            s1 = bus.pwm_in;
            if (!bus.ena) begin
                m_active = 0;
            end else if (!m_active) begin
                m_active = 1; m_aligned = 0; m_nohit = 0; m_prev = 1;
                win_q.delete();
            end else if (bus.step) begin
                if (!m_aligned) begin
                    if (s && !m_prev) begin
                        m_aligned = 1;
                        win_q.push_back(1);
                    end else begin
                        m_nohit++;
                        if (m_nohit == WIN) begin
                            e_duty = s ? WIN - 1 : 0; e_stuck = 1; e_valid = 1;
                            m_pulses++;
                            m_nohit = 0;
                        end
                    end
                end else begin
                    win_q.push_back(int'(s));
                    if (win_q.size() == WIN) begin
                        sum = 0;
                        foreach (win_q[i]) sum += win_q[i];
                        e_duty = (sum > WIN - 1) ? WIN - 1 : sum;
                        e_stuck = 0; e_valid = 1;
                        m_pulses++;
                        win_q.delete();
                    end
                end
                m_prev = s;
            end
        end
    end

    // Stimulus state
    string cur_tag = "init";
    int    wmode = 0;      // 0 constant, 1 periodic 16/5, 2 low-then-high
    bit    wlevel = 0;
    int    phase = 0;
    bit    rand_mode = 0;
    int    dut_pulses = 0;

    function automatic bit wave(input int ph);
        case (wmode)
            1:       return (ph % WIN) < 5;
            2:       return ph >= 4;
            default: return wlevel;
        endcase
    endfunction

    task automatic tick();
        @(negedge clk);
        check({cur_tag, "_valid"}, int'(bus.valid), int'(e_valid));
        check({cur_tag, "_duty"},  int'(bus.duty),  e_duty);
        check({cur_tag, "_stuck"}, int'(bus.stuck), int'(e_stuck));
        if (bus.valid) dut_pulses++;
        if (rand_mode) begin
            bus.step = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) bus.pwm_in = ~bus.pwm_in;
        end else begin
            if (bus.step) phase++;
            bus.step   = ~bus.step;
            bus.pwm_in = wave(phase);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start(input string tag, input int mode, input bit level);
        cur_tag = tag;
        bus.ena = 1'b0;
        wmode = mode; wlevel = level; phase = 0;
        bus.step = 1'b0;
        bus.pwm_in = wave(0);
        ticks(6);
        dut_pulses = 0; m_pulses = 0;
        bus.ena = 1'b1;
    endtask

    task automatic wait_valid(input string tag);
        bit seen;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            if (bus.valid) seen = 1;
        end
        if (!seen) check({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        bus.ena = 1'b0; bus.step = 1'b0; bus.pwm_in = 1'b0;
        rst = 1'b1;
        ticks(3);
        check("rst_duty",  int'(bus.duty),  0);
        check("rst_valid", int'(bus.valid), 0);
        check("rst_stuck", int'(bus.stuck), 0);
        rst = 1'b0;

        // Periodic 16-step period, 5 high
        start("s29", 1, 0);
        ticks(440);
        check("s29_pulses", dut_pulses, m_pulses);
        check("s29_duty_final",  int'(bus.duty),  5);
        check("s29_stuck_final", int'(bus.stuck), 0);

        // Input stuck low
        start("s30", 0, 0);
        ticks(80);
        check("s30_duty_final",  int'(bus.duty),  0);
        check("s30_stuck_final", int'(bus.stuck), 1);
        check("s30_pulses", dut_pulses, 2);

        // Input stuck high before enable
        start("s31", 0, 1);
        ticks(80);
        check("s31_duty_final",  int'(bus.duty),  WIN - 1);
        check("s31_stuck_final", int'(bus.stuck), 1);

        // One rising edge then all-high window saturates
        start("s32", 2, 0);
        ticks(80);
        check("s32_duty_final",  int'(bus.duty),  WIN - 1);
        check("s32_stuck_final", int'(bus.stuck), 0);
        check("s32_pulses", dut_pulses, m_pulses);

        // Enable dropped mid-window after duty=5 published
        start("s33", 1, 0);
        wait_valid("s33");
        wait_valid("s33b");
        ticks(18);
        bus.ena = 1'b0;
        dut_pulses = 0;
        ticks(40);
        check("s33_off_pulses", dut_pulses, 0);
        check("s33_off_duty",   int'(bus.duty), 5);
        bus.ena = 1'b1;
        ticks(200);

        // Reset in the middle of a measured window
        start("s34", 1, 0);
        wait_valid("s34");
        wait_valid("s34b");
        ticks(10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("s34_rst_duty",  int'(bus.duty),  0);
        check("s34_rst_stuck", int'(bus.stuck), 0);
        check("s34_rst_valid", int'(bus.valid), 0);
        dut_pulses = 0;
        ticks(30);
        check("s34_no_early_valid", dut_pulses, 0);
        ticks(100);

        // Randomized stimulus: step, waveform, enable and reset
        cur_tag = "rnd";
        rand_mode = 1;
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 149) == 0) bus.ena = ~bus.ena;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pwm_decoder.md
PWM_DECODER -- requirements
Module: pwm_decoder

Interface
REQ-001 SHALL have parameter N, default 8, meaning duty resolution in bits; measurement window = 2^N samples.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port ena  input  1  enables measurement; low forces idle.
REQ-005 SHALL have port step  input  1  sample strobe; input sampled and counters advance only when high.
REQ-006 SHALL have port pwm_in  input  1  asynchronous PWM waveform to decode.
REQ-007 SHALL have port duty  output  N  last published duty estimate, held between updates.
REQ-008 SHALL have port valid  output  1  one-clk pulse when duty/stuck are updated.
REQ-009 SHALL have port stuck  output  1  last publication came from a no-edge timeout, not a measured window.

Function
REQ-010 SHALL pass pwm_in through a 2-flop synchronizer clocked every clk, independent of step and ena.
REQ-011 SHALL take a sample only on clk edges where ena=1 and step=1, and SHALL keep prev_sample, the previous sample's value.
REQ-012 SHALL define a rising edge as sample=1 with prev_sample=0.
REQ-013 SHALL implement FSM states IDLE, ALIGN, MEASURE.
REQ-014 IDLE: ena=1 -> ALIGN on the next clk, with sample index and high count cleared.
REQ-015 ALIGN: a sample that is a rising edge -> MEASURE; that sample counts as window sample 1 with high count 1.
REQ-016 ALIGN timeout: 2^N samples with no rising edge -> publish duty = all-ones if the latest sample is 1, else 0; set stuck=1; stay in ALIGN with the timeout counter cleared.
REQ-017 MEASURE: each sample increments sample index; high count increments when sample=1.
REQ-018 SHALL use an N+1-bit high count (range 0..2^N).
REQ-019 On the 2^N-th window sample: publish duty = min(high count, 2^N-1) (saturating), stuck=0, pulse valid; start the next window back-to-back on the next sample, with no realignment.
REQ-020 duty, stuck and valid SHALL register on the clk edge after the completing sample (latency 1 clk); valid SHALL be high for exactly that clk.
REQ-021 step=0 SHALL freeze sample index, high count, timeout counter and prev_sample.
REQ-022 ena=0 SHALL force IDLE on the next clk: discard the partial window, valid=0, duty and stuck held.
REQ-023 When rst=1, rst SHALL take priority over ena and step.

Reset
REQ-024 On rst: duty=0, valid=0, stuck=0, state=IDLE, counters=0, synchronizer flops=0, prev_sample=1 (a high input at enable is not a rising edge).
REQ-025 Reset asserted mid-window SHALL discard that window without a valid pulse.

Structure
REQ-026 Shared package pwm_pkg SHALL hold the FSM state enum typedef (IDLE/ALIGN/MEASURE) and the default-N constant.
REQ-027 The synchronizer SHALL be a separate sub-module sync2 (1-bit, 2 flops, reset to 0); all other logic stays in pwm_decoder.
REQ-028 RTL SHALL keep one always_ff for state/counters/outputs and one always_comb for next-state and publish decisions.

Verification (N=4, step every 2nd clk)
REQ-029 Periodic input, period 16 steps, 5 steps high, ena=1 -> after alignment, valid pulses every 16 steps with duty=5, stuck=0.
REQ-030 pwm_in held 0, ena raised -> after 16 samples valid with duty=0, stuck=1; repeats every 16 samples.
REQ-031 pwm_in held 1 from before ena -> no rising edge; after 16 samples valid with duty=15, stuck=1.
REQ-032 One rising edge, then input high for all 16 window samples -> high count 16 saturates: duty=15, stuck=0.
REQ-033 ena dropped at window sample 9 after duty=5 was published -> no valid, duty stays 5; on re-enable, realigns in ALIGN before the next publication.
REQ-034 rst pulsed in MEASURE -> next clk duty=0, stuck=0, valid=0, state IDLE; no valid until a full new window completes.
